iterative_alu: RTL and testbench

Handshaked, multi-cycle ALU that generalises the team's single-cycle ALU: width-parametrised datapath, valid/ready on both input and output, iterative shift-add multiplier and restoring divider, variable shift/rotate amounts and a registered status-flag vector. Sits between the instruction decoder and the register-file write-back stage. Issue only when InReady is high; consume results only when OutValid is high.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/iterative_muldiv.sv | 79 +++++++
 rtl/iterative_alu.sv | 184 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
// Opcodes, FSM states, flag bit positions, mul/div select.
package alu_pkg;

  localparam int OP_NOP  = 'h00;
  localparam int OP_ADD  = 'h01;
  localparam int OP_SUB  = 'h02;
  localparam int OP_MUL  = 'h03;
  localparam int OP_DIV  = 'h04;
  localparam int OP_SHL  = 'h05;
  localparam int OP_SHR  = 'h06;
  localparam int OP_ROL  = 'h07;
  localparam int OP_ROR  = 'h08;
  localparam int OP_AND  = 'h09;
  localparam int OP_XOR  = 'h0B;
  localparam int OP_OR   = 'h0D;
  localparam int OP_NAND = 'h0E;
  localparam int OP_XNOR = 'h0F;
  localparam int OP_GTH  = 'h10;
  localparam int OP_EQU  = 'h11;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_DBZ   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } md_sel_e;

  function automatic logic [3:0] pack_flags(
    input logic z,
    input logic c,
    input logic n,
    input logic d
  );
    logic [3:0] f;
    f = '0;
    f[FLG_ZERO]  = z;
    f[FLG_CARRY] = c;
    f[FLG_NEG]   = n;
    f[FLG_DBZ]   = d;
    return f;
  endfunction

endpackage

// File: rtl/iterative_muldiv.sv
// Shared shift-add multiplier / restoring divider.
// One iteration per cycle; o_done high once the counter is 0.
module iterative_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  md_sel_e               i_mode,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  md_sel_e       r_mode;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [CW-1:0] r_cnt;

  logic [W:0]    w_shift;
  logic [W:0]    w_x;
  logic [W:0]    w_y;
  logic [W+1:0]  w_sum;
  logic [W:0]    w_p;
  logic          w_div;

  // One adder serves both modes: add multiplicand or subtract divisor.
  always_comb begin
    w_div   = (r_mode == MD_DIV);
    w_shift = {r_hi, r_lo[W-1]};
    w_x     = w_div ? w_shift : {1'b0, r_hi};
    w_y     = w_div ? ~{1'b0, r_b} : {1'b0, r_b};
    w_sum   = {1'b0, w_x} + {1'b0, w_y}
            + {{(W+1){1'b0}}, w_div};
    w_p     = r_lo[0] ? w_sum[W:0] : {1'b0, r_hi};
  end

  // Load on start, then iterate until the counter drains.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_mode <= MD_MUL;
    end else if (i_start) begin
      r_cnt  <= CW'(DATA_WIDTH);
      r_hi   <= '0;
      r_lo   <= i_a;
      r_b    <= i_b;
      r_mode <= i_mode;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (!w_div) begin
        r_hi <= w_p[W:1];
        r_lo <= {w_p[0], r_lo[W-1:1]};
      end else if (w_sum[W+1]) begin
        r_hi <= w_sum[W-1:0];
        r_lo <= {r_lo[W-2:0], 1'b1};
      end else begin
        r_hi <= w_shift[W-1:0];
        r_lo <= {r_lo[W-2:0], 1'b0};
      end
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

endmodule

// File: rtl/iterative_alu.sv
// Handshaked multi-cycle ALU: FSM, single-cycle unit,
// registered results and flags, iterative mul/div.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 5,
  parameter int FLAGS_COUNT = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  input  logic [DATA_WIDTH-1:0]  InputA,
  input  logic [DATA_WIDTH-1:0]  InputB,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [DATA_WIDTH-1:0]  ResultA,
  output logic [DATA_WIDTH-1:0]  ResultB,
  output logic [FLAGS_COUNT-1:0] Flags
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] LW = W'(DATA_WIDTH);

  state_e                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [W-1:0]           r_res_a;
  logic [W-1:0]           r_res_b;
  logic [FLAGS_COUNT-1:0] r_flags;
  logic [INSTR_WIDTH-1:0] r_op;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;

  logic [31:0]  w_op;
  logic [31:0]  w_in_op;
  logic         w_acc;
  logic         w_in_md;
  logic         w_start;
  md_sel_e      w_mode;
  logic         w_md_done;
  logic [W-1:0] w_md_lo;
  logic [W-1:0] w_md_hi;
  logic [W-1:0] w_mod;
  logic [W-1:0] w_rev;
  logic [W-1:0] w_sc_res;
  logic         w_sc_carry;
  logic [W-1:0] w_res_a;
  logic [W-1:0] w_res_b;
  logic         w_carry;
  logic         w_dbz;
  logic [3:0]   w_flags;

  assign w_op    = 32'(r_op);
  assign w_in_op = 32'(Instruction);
  assign w_acc   = InValid & r_in_ready;
  assign w_in_md = (w_in_op == OP_MUL)
                 | (w_in_op == OP_DIV);
  assign w_start = w_acc & w_in_md;
  assign w_mode  = (w_in_op == OP_DIV) ? MD_DIV : MD_MUL;

  iterative_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .i_clk  (Clk),
    .i_reset(Reset),
    .i_start(w_start),
    .i_mode (w_mode),
    .i_a    (InputA),
    .i_b    (InputB),
    .o_done (w_md_done),
    .o_lo   (w_md_lo),
    .o_hi   (w_md_hi)
  );

  assign w_mod = r_b % LW;
  assign w_rev = LW - w_mod;

  // Single-cycle unit on the captured operands.
  always_comb begin
    w_sc_res   = r_a;
    w_sc_carry = 1'b0;
    case (w_op)
      OP_ADD: {w_sc_carry, w_sc_res} =
                {1'b0, r_a} + {1'b0, r_b};
      OP_SUB: begin
        w_sc_res   = r_a - r_b;
        w_sc_carry = (r_a < r_b);
      end
      OP_SHL:  w_sc_res = r_a << w_mod;
      OP_SHR:  w_sc_res = r_a >> w_mod;
      OP_ROL:  w_sc_res = (r_a << w_mod)
                        | (r_a >> w_rev);
      OP_ROR:  w_sc_res = (r_a >> w_mod)
                        | (r_a << w_rev);
      OP_AND:  w_sc_res = r_a & r_b;
      OP_XOR:  w_sc_res = r_a ^ r_b;
      OP_OR:   w_sc_res = r_a | r_b;
      OP_NAND: w_sc_res = ~(r_a & r_b);
      OP_XNOR: w_sc_res = ~(r_a ^ r_b);
      OP_GTH:  w_sc_res = (r_a > r_b) ? '1 : '0;
      OP_EQU:  w_sc_res = (r_a == r_b) ? '1 : '0;
      default: w_sc_res = r_a;
    endcase
  end

  // Pick the result source and derive flags.
  always_comb begin
    w_res_a = w_sc_res;
    w_res_b = '0;
    w_carry = w_sc_carry;
    w_dbz   = 1'b0;
    if (w_op == OP_MUL) begin
      w_res_a = w_md_lo;
      w_res_b = w_md_hi;
      w_carry = |w_md_hi;
    end else if (w_op == OP_DIV) begin
      w_res_a = w_md_lo;
      w_res_b = w_md_hi;
      w_carry = 1'b0;
      w_dbz   = (r_b == '0);
    end
    w_flags = pack_flags(w_res_a == '0, w_carry,
                         w_res_a[W-1], w_dbz);
  end

  // Control FSM with registered handshake and results.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res_a     <= '0;
      r_res_b     <= '0;
      r_flags     <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_op       <= Instruction;
            r_a        <= InputA;
            r_b        <= InputB;
            r_in_ready <= 1'b0;
            r_state    <= w_in_md ? ST_EXEC : ST_DONE;
          end
        end
        ST_EXEC: begin
          if (w_md_done) begin
            r_res_a     <= w_res_a;
            r_res_b     <= w_res_b;
            r_flags     <= FLAGS_COUNT'(w_flags);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_res_a     <= w_res_a;
            r_res_b     <= w_res_b;
            r_flags     <= FLAGS_COUNT'(w_flags);
            r_out_valid <= 1'b1;
          end else if (OutReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign ResultA  = r_res_a;
  assign ResultB  = r_res_b;
  assign Flags    = r_flags;

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu, DATA_WIDTH=8.
// Directed vectors with hand-computed results.
module tb_iterative_alu;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       InValid = 1'b0;
  logic       OutReady = 1'b1;
  logic [4:0] Instruction = '0;
  logic [7:0] InputA = '0;
  logic [7:0] InputB = '0;
  logic       InReady;
  logic       OutValid;
  logic [7:0] ResultA;
  logic [7:0] ResultB;
  logic [3:0] Flags;

  iterative_alu #(
    .DATA_WIDTH (8),
    .INSTR_WIDTH(5),
    .FLAGS_COUNT(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .Instruction(Instruction),
    .InputA     (InputA),
    .InputB     (InputB),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .ResultA    (ResultA),
    .ResultB    (ResultB),
    .Flags      (Flags)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: pop and compare on every consumed result.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && OutValid === 1'b1 && OutReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%0h want=none",
                 ResultA);
      end else begin
        e = q.pop_front();
        chk({e.name, "_resA"}, ResultA, e.a);
        chk({e.name, "_resB"}, ResultB, e.b);
        chk({e.name, "_flags"}, Flags, e.f);
      end
    end
  end

  task automatic issue(input string nm,
                       input logic [4:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] ea,
                       input logic [7:0] eb,
                       input logic [3:0] ef,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    while (InReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_inready"}, InReady, 1);
    Instruction = op;
    InputA = a;
    InputB = b;
    InValid = 1'b1;
    if (push) begin
      e.name = nm;
      e.a = ea;
      e.b = eb;
      e.f = ef;
      q.push_back(e);
    end
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_valid(output int lat,
                            output bit saw);
    lat = 0;
    saw = 1'b0;
    @(negedge Clk);
    while (OutValid !== 1'b1 && lat < 40) begin
      saw |= InReady;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run(input string nm,
                     input logic [4:0] op,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] ea,
                     input logic [7:0] eb,
                     input logic [3:0] ef,
                     input int elat);
    int lat;
    bit saw;
    issue(nm, op, a, b, ea, eb, ef, 1'b1);
    wait_valid(lat, saw);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_inready"}, 32'(saw), 0);
    tick();
    chk({nm, "_ready_after"}, InReady, 1);
    chk({nm, "_valid_after"}, OutValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit saw;

    Reset = 1'b1;
    repeat (2) tick();
    @(negedge Clk);
    chk("rst_inready", InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_resA", ResultA, 0);
    chk("rst_resB", ResultB, 0);
    chk("rst_flags", Flags, 0);
    tick();
    Reset = 1'b0;

    run("add", 5'h01, 8'hF0, 8'h20,
        8'h10, 8'h00, 4'b0010, 1);
    run("sub_eq", 5'h02, 8'h05, 8'h05,
        8'h00, 8'h00, 4'b0001, 1);
    run("sub_neg", 5'h02, 8'h03, 8'h05,
        8'hFE, 8'h00, 4'b0110, 1);
    run("mul", 5'h03, 8'h12, 8'h34,
        8'hA8, 8'h03, 4'b0110, 9);
    run("mul_small", 5'h03, 8'h0F, 8'h0F,
        8'hE1, 8'h00, 4'b0100, 9);
    run("div", 5'h04, 8'd100, 8'd7,
        8'd14, 8'd2, 4'b0000, 9);
    run("div0", 5'h04, 8'h05, 8'h00,
        8'hFF, 8'h05, 4'b1100, 9);
    run("shl", 5'h05, 8'h81, 8'h03,
        8'h08, 8'h00, 4'b0000, 1);
    run("shr", 5'h06, 8'h81, 8'h03,
        8'h10, 8'h00, 4'b0000, 1);
    run("ror", 5'h08, 8'h81, 8'h01,
        8'hC0, 8'h00, 4'b0100, 1);
    run("rol0", 5'h07, 8'h81, 8'h08,
        8'h81, 8'h00, 4'b0100, 1);
    run("xor", 5'h0B, 8'hF0, 8'h3C,
        8'hCC, 8'h00, 4'b0100, 1);
    run("nand", 5'h0E, 8'hFF, 8'h0F,
        8'hF0, 8'h00, 4'b0100, 1);
    run("gth", 5'h10, 8'h05, 8'h03,
        8'hFF, 8'h00, 4'b0100, 1);
    run("equ", 5'h11, 8'h05, 8'h03,
        8'h00, 8'h00, 4'b0001, 1);
    run("badop", 5'h0A, 8'h37, 8'h12,
        8'h37, 8'h00, 4'b0000, 1);

    OutReady = 1'b0;
    issue("rol", 5'h07, 8'h81, 8'h09,
          8'h03, 8'h00, 4'b0000, 1'b1);
    wait_valid(lat, saw);
    chk("rol_latency", lat, 1);
    Instruction = 5'h01;
    InputA = 8'h01;
    InputB = 8'h01;
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("hold_valid", OutValid, 1);
      chk("hold_resA", ResultA, 8'h03);
      chk("hold_resB", ResultB, 8'h00);
      chk("hold_flags", Flags, 4'b0000);
      chk("hold_inready", InReady, 0);
    end
    tick();
    InValid = 1'b0;
    OutReady = 1'b1;
    tick();
    chk("hold_ready_after", InReady, 1);
    repeat (2) tick();
    chk("hold_no_extra", OutValid, 0);

    issue("mul_rst", 5'h03, 8'h12, 8'h34,
          8'h00, 8'h00, 4'b0000, 1'b0);
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("mrst_outvalid", OutValid, 0);
    chk("mrst_inready", InReady, 1);
    chk("mrst_resA", ResultA, 0);
    chk("mrst_resB", ResultB, 0);
    chk("mrst_flags", Flags, 0);
    repeat (12) begin
      @(negedge Clk);
      chk("mrst_quiet", OutValid, 0);
    end
    tick();
    run("add_post", 5'h01, 8'h01, 8'h01,
        8'h02, 8'h00, 4'b0000, 1);

    repeat (3) tick();
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
